// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the per-stage event tracker:
//   - game state codes produced by the game-play FSM
//   - object kind codes reported to the renderer
//   - default sprite/object geometry and hold length
//   - per-stage object tables (key, light and door positions in pixels)
//   - objEntry(): looks up the Nth target object of a stage
// ----------------------------------------------------------------------------
package game_pkg;

   // Game state codes as driven by the upstream game-play FSM
   typedef enum logic [3:0] {
      GS_TITLE    = 4'd0,
      GS_STAFF    = 4'd1,
      GS_STAGE1   = 4'd2,
      GS_SUCCESS1 = 4'd3,
      GS_STAGE2   = 4'd4,
      GS_SUCCESS2 = 4'd5,
      GS_STAGE3   = 4'd6,
      GS_SUCCESS3 = 4'd7,
      GS_FAIL     = 4'd8
   } game_state_e;

   // Kind of the object the player currently has to reach
   typedef enum logic [1:0] {
      OBJ_NONE  = 2'd0,
      OBJ_KEY   = 2'd1,
      OBJ_LIGHT = 2'd2,
      OBJ_DOOR  = 2'd3
   } obj_kind_e;

   localparam int PLAYER_W_DEFAULT   = 11;
   localparam int OBJ_W_DEFAULT      = 10;
   localparam int HOLD_TICKS_DEFAULT = 2;
   localparam int COORD_W            = 9;

   // One row of a stage object table
   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      obj_kind_e          kind;
   } obj_entry_t;

   // Key positions per stage, in collection order
   localparam logic [COORD_W-1:0] STAGE1_KEY_X [3] = '{9'd100, 9'd200, 9'd230};
   localparam logic [COORD_W-1:0] STAGE1_KEY_Y [3] = '{9'd40,  9'd60,  9'd200};
   localparam logic [COORD_W-1:0] STAGE2_KEY_X [3] = '{9'd120, 9'd180, 9'd70};
   localparam logic [COORD_W-1:0] STAGE2_KEY_Y [3] = '{9'd100, 9'd130, 9'd190};
   localparam logic [COORD_W-1:0] STAGE3_KEY_X [3] = '{9'd90,  9'd200, 9'd240};
   localparam logic [COORD_W-1:0] STAGE3_KEY_Y [3] = '{9'd210, 9'd210, 9'd40};

   // Light exists only in stage 2; the door is shared by all stages
   localparam logic [COORD_W-1:0] LIGHT_X = 9'd70;
   localparam logic [COORD_W-1:0] LIGHT_Y = 9'd40;
   localparam logic [COORD_W-1:0] DOOR_X  = 9'd250;
   localparam logic [COORD_W-1:0] DOOR_Y  = 9'd120;

   function automatic logic isStage(input logic [3:0] gs);
      return (gs == GS_STAGE1) || (gs == GS_STAGE2) || (gs == GS_STAGE3);
   endfunction

   // Stage 2 puts the light in slot 0, so its keys and door sit one slot
   // later than in the other stages. Anything past the door reads as NONE.
   function automatic obj_entry_t objEntry(input logic [3:0] gs,
                                           input logic [2:0] idx);
      obj_entry_t e;
      logic [2:0] slot;
      e.x    = '0;
      e.y    = '0;
      e.kind = OBJ_NONE;
      slot   = idx;
      if ((gs == GS_STAGE2) && (idx == 3'd0)) begin
         e.x    = LIGHT_X;
         e.y    = LIGHT_Y;
         e.kind = OBJ_LIGHT;
      end else begin
         if (gs == GS_STAGE2) begin
            slot = idx - 3'd1;
         end
         if (slot == 3'd3) begin
            e.x    = DOOR_X;
            e.y    = DOOR_Y;
            e.kind = OBJ_DOOR;
         end else if (slot < 3'd3) begin
            e.kind = OBJ_KEY;
            case (gs)
               GS_STAGE1: begin
                  e.x = STAGE1_KEY_X[slot[1:0]];
                  e.y = STAGE1_KEY_Y[slot[1:0]];
               end
               GS_STAGE2: begin
                  e.x = STAGE2_KEY_X[slot[1:0]];
                  e.y = STAGE2_KEY_Y[slot[1:0]];
               end
               GS_STAGE3: begin
                  e.x = STAGE3_KEY_X[slot[1:0]];
                  e.y = STAGE3_KEY_Y[slot[1:0]];
               end
               default: begin
                  e.kind = OBJ_NONE;
               end
            endcase
         end
      end
      return e;
   endfunction

endpackage

// File: rtl/box_overlap.sv
// ----------------------------------------------------------------------------
// box_overlap
// Combinational axis-aligned box overlap test. Box A spans ax..ax+A_W-1 and
// ay..ay+A_W-1, box B likewise with B_W. Sums are formed one bit wider than
// the coordinates so the right/bottom edge never wraps.
// Ports:
//   ax_i, ay_i : box A top-left corner
//   bx_i, by_i : box B top-left corner
//   hit_o      : 1 when the boxes share at least one pixel
// ----------------------------------------------------------------------------
module box_overlap #(
   parameter int COORD_W = 9,
   parameter int A_W     = 11,
   parameter int B_W     = 10
) (
   input  logic [COORD_W-1:0] ax_i,
   input  logic [COORD_W-1:0] ay_i,
   input  logic [COORD_W-1:0] bx_i,
   input  logic [COORD_W-1:0] by_i,
   output logic               hit_o
);

   localparam int EXT_W = COORD_W + 1;
   localparam logic [EXT_W-1:0] A_SPAN = EXT_W'(A_W - 1);
   localparam logic [EXT_W-1:0] B_SPAN = EXT_W'(B_W - 1);

   logic [EXT_W-1:0] axExt, ayExt, bxExt, byExt;
   logic             xHit, yHit;

   // Each axis overlaps when neither box starts past the far edge of the other
   always_comb begin
      axExt = {1'b0, ax_i};
      ayExt = {1'b0, ay_i};
      bxExt = {1'b0, bx_i};
      byExt = {1'b0, by_i};
      xHit  = (axExt <= (bxExt + B_SPAN)) && (bxExt <= (axExt + A_SPAN));
      yHit  = (ayExt <= (byExt + B_SPAN)) && (byExt <= (ayExt + A_SPAN));
      hit_o = xHit && yHit;
   end

endmodule

// File: rtl/stage_event_unit.sv
// ----------------------------------------------------------------------------
// stage_event_unit
// Per-stage gameplay event tracker. Walks the current stage's object list
// (light, keys, door), confirms each pickup after the player has overlapped
// it for HOLD_TICKS consecutive movement ticks, and watches for the boss
// catching the player in stage 3.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   tick                : one-clk pulse per movement step
//   state               : game state code from the game-play FSM
//   player_x/_y         : player box top-left corner
//   boss_x/_y           : boss box top-left corner
//   key_find            : keys collected in this stage (saturates at 3)
//   isDark              : stage 2 light not yet found
//   pass, fail          : one-clk pulses for door reached / player caught
//   obj_x, obj_y        : current target object top-left corner
//   obj_kind            : current target kind (NONE/KEY/LIGHT/DOOR)
// ----------------------------------------------------------------------------
module stage_event_unit
   import game_pkg::*;
#(
   parameter int PLAYER_W   = PLAYER_W_DEFAULT,
   parameter int OBJ_W      = OBJ_W_DEFAULT,
   parameter int HOLD_TICKS = HOLD_TICKS_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic [3:0]         state,
   input  logic [COORD_W-1:0] player_x,
   input  logic [COORD_W-1:0] player_y,
   input  logic [COORD_W-1:0] boss_x,
   input  logic [COORD_W-1:0] boss_y,
   output logic [1:0]         key_find,
   output logic               isDark,
   output logic               pass,
   output logic               fail,
   output logic [COORD_W-1:0] obj_x,
   output logic [COORD_W-1:0] obj_y,
   output logic [1:0]         obj_kind
);

   typedef enum logic [2:0] {
      FSM_IDLE    = 3'd0,
      FSM_LOAD    = 3'd1,
      FSM_SEEK    = 3'd2,
      FSM_CONFIRM = 3'd3,
      FSM_DONE    = 3'd4
   } fsm_e;

   localparam logic [2:0] HOLD_L = 3'(HOLD_TICKS);

   fsm_e               fsm_q;
   logic [3:0]         prevState_q;
   logic [2:0]         objIdx_q;
   logic [2:0]         holdCnt_q;
   logic [1:0]         keyFind_q;
   logic               isDark_q;
   logic               pass_q;
   logic               fail_q;
   logic [COORD_W-1:0] objX_q;
   logic [COORD_W-1:0] objY_q;
   obj_kind_e          objKind_q;

   logic               objHit;
   logic               bossHit;
   logic               leaveStage_d;
   logic               tracking_d;
   logic               catch_d;
   logic               confirm_d;
   logic [2:0]         holdNext_d;
   obj_entry_t         loadObj_d;
   obj_entry_t         nextObj_d;

   box_overlap #(
      .COORD_W (COORD_W),
      .A_W     (PLAYER_W),
      .B_W     (OBJ_W)
   ) uObjOverlap (
      .ax_i  (player_x),
      .ay_i  (player_y),
      .bx_i  (objX_q),
      .by_i  (objY_q),
      .hit_o (objHit)
   );

   box_overlap #(
      .COORD_W (COORD_W),
      .A_W     (PLAYER_W),
      .B_W     (PLAYER_W)
   ) uBossOverlap (
      .ax_i  (player_x),
      .ay_i  (player_y),
      .bx_i  (boss_x),
      .by_i  (boss_y),
      .hit_o (bossHit)
   );

   // Event decode for this cycle. Any change of game state while active
   // (including a jump straight to another stage) drops back to IDLE so the
   // new stage always reloads from scratch. A catch outranks a confirm.
   always_comb begin
      leaveStage_d = !isStage(state) || (state != prevState_q);
      tracking_d   = (fsm_q == FSM_SEEK) || (fsm_q == FSM_CONFIRM);
      holdNext_d   = holdCnt_q + 3'd1;
      catch_d      = tracking_d && tick && bossHit && (state == GS_STAGE3);
      confirm_d    = tick && objHit && (objKind_q != OBJ_NONE) &&
                     (((fsm_q == FSM_SEEK) && (HOLD_L == 3'd1)) ||
                      ((fsm_q == FSM_CONFIRM) && (holdNext_d >= HOLD_L)));
      loadObj_d    = objEntry(state, 3'd0);
      nextObj_d    = objEntry(state, objIdx_q + 3'd1);
   end

   // Stage tracking FSM with registered outputs. pass/fail default low so
   // they can only ever be one-cycle pulses; the catch branch is taken before
   // the confirm branch so a simultaneous catch leaves keys/light untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q       <= FSM_IDLE;
         prevState_q <= 4'd0;
         objIdx_q    <= 3'd0;
         holdCnt_q   <= 3'd0;
         keyFind_q   <= 2'd0;
         isDark_q    <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         objX_q      <= '0;
         objY_q      <= '0;
         objKind_q   <= OBJ_NONE;
      end else begin
         prevState_q <= state;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         if ((fsm_q != FSM_IDLE) && leaveStage_d) begin
            fsm_q     <= FSM_IDLE;
            objIdx_q  <= 3'd0;
            holdCnt_q <= 3'd0;
            keyFind_q <= 2'd0;
            isDark_q  <= 1'b0;
            objX_q    <= '0;
            objY_q    <= '0;
            objKind_q <= OBJ_NONE;
         end else begin
            case (fsm_q)
               FSM_IDLE: begin
                  if (isStage(state)) begin
                     fsm_q <= FSM_LOAD;
                  end
               end
               FSM_LOAD: begin
                  keyFind_q <= 2'd0;
                  isDark_q  <= (state == GS_STAGE2);
                  objIdx_q  <= 3'd0;
                  holdCnt_q <= 3'd0;
                  objX_q    <= loadObj_d.x;
                  objY_q    <= loadObj_d.y;
                  objKind_q <= loadObj_d.kind;
                  fsm_q     <= FSM_SEEK;
               end
               FSM_SEEK, FSM_CONFIRM: begin
                  if (catch_d) begin
                     fail_q    <= 1'b1;
                     holdCnt_q <= 3'd0;
                     fsm_q     <= FSM_DONE;
                  end else if (confirm_d) begin
                     holdCnt_q <= 3'd0;
                     if (objKind_q == OBJ_DOOR) begin
                        pass_q    <= 1'b1;
                        objKind_q <= OBJ_NONE;
                        fsm_q     <= FSM_DONE;
                     end else begin
                        if ((objKind_q == OBJ_KEY) && (keyFind_q != 2'd3)) begin
                           keyFind_q <= keyFind_q + 2'd1;
                        end
                        if (objKind_q == OBJ_LIGHT) begin
                           isDark_q <= 1'b0;
                        end
                        objIdx_q  <= objIdx_q + 3'd1;
                        objX_q    <= nextObj_d.x;
                        objY_q    <= nextObj_d.y;
                        objKind_q <= nextObj_d.kind;
                        fsm_q     <= FSM_SEEK;
                     end
                  end else if (tick) begin
                     if (objHit) begin
                        holdCnt_q <= (fsm_q == FSM_SEEK) ? 3'd1 : holdNext_d;
                        fsm_q     <= FSM_CONFIRM;
                     end else begin
                        holdCnt_q <= 3'd0;
                        fsm_q     <= FSM_SEEK;
                     end
                  end
               end
               FSM_DONE: begin
               end
               default: begin
                  fsm_q <= FSM_IDLE;
               end
            endcase
         end
      end
   end

   assign key_find = keyFind_q;
   assign isDark   = isDark_q;
   assign pass     = pass_q;
   assign fail     = fail_q;
   assign obj_x    = objX_q;
   assign obj_y    = objY_q;
   assign obj_kind = objKind_q;

endmodule

// File: doc/stage_event_unit.md
Name: stage_event_unit

Overview:
Per-stage gameplay event tracker that sits directly downstream of the game-play/player-movement block. It consumes the game state and the player/boss positions. It produces the objective signals that the game-play FSM and todo logic depend on: key_find, isDark, pass, fail, and the current target object position and kind for the renderer. Each objective is confirmed by box-overlap tests sampled on the movement tick.

Parameters:
PLAYER_W, 11, player/boss sprite box edge in pixels (box spans x..x+PLAYER_W-1)
OBJ_W, 10, object (key/light/door) box edge in pixels
HOLD_TICKS, 2, consecutive overlapping ticks required to confirm a pickup or door entry (range 1..7)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
tick  input  1  one-clk pulse per movement step (clk_23 period), synchronous to clk
state  input  4  game state code (TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8)
player_x  input  9  player box left edge, pixels
player_y  input  9  player box top edge, pixels
boss_x  input  9  boss box left edge
boss_y  input  9  boss box top edge
key_find  output  2  keys collected this stage, 0..3
isDark  output  1  stage is dark (light not yet found)
pass  output  1  one-clk pulse: door reached with 3 keys
fail  output  1  one-clk pulse: boss caught player (STAGE3 only)
obj_x  output  9  current target object left edge
obj_y  output  9  current target object top edge
obj_kind  output  2  NONE=0, KEY=1, LIGHT=2, DOOR=3

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; key_find=0, isDark=0, pass=0, fail=0, obj_x=0, obj_y=0, obj_kind=NONE.
- FSM states: IDLE, LOAD, SEEK, CONFIRM, DONE.
- IDLE: all outputs are held at their reset values. When state becomes STAGE1/2/3 (or state differs from the registered previous state and the new state is a stage), go to LOAD.
- LOAD (1 cycle): key_find<=0; isDark<=(state==STAGE2); obj index<=0; obj_x/obj_y/obj_kind are loaded from the stage table. Object order is STAGE2: LIGHT, K0, K1, K2, DOOR; STAGE1/STAGE3: K0, K1, K2, DOOR. Outputs are valid 2 clk after the state change. A tick during LOAD is ignored. Then go to SEEK.
- Overlap test: a.x <= b.x+wb-1 AND b.x <= a.x+wa-1, and the same for y. Computed in 10 bits with no wrap.
- SEEK: on tick with player/object overlap, hold counter<=1. If HOLD_TICKS==1, confirm immediately; otherwise go to CONFIRM.
- CONFIRM: on tick with overlap, increment the counter and confirm when it reaches HOLD_TICKS. On tick without overlap, reset the counter and return to SEEK. Cycles without a tick hold the counter.
- Confirm, all on the same edge:
  - KEY: key_find+1 and advance to the next object.
  - LIGHT: isDark<=0 and advance.
  - DOOR: pass<=1 for one cycle, obj_kind<=NONE, go to DONE.
  - After any confirm, the counter clears and the FSM returns to SEEK unless it entered DONE.
- Boss: in STAGE3 during SEEK/CONFIRM, a tick with player/boss overlap (both boxes PLAYER_W) gives fail<=1 for one cycle and DONE. There is no hold requirement.
- Simultaneous events: boss catch and a confirm on the same tick gives fail only; key_find and isDark are unchanged.
- key_find saturates at 3 and never wraps. DOOR is reachable only after 3 keys because of the object order.
- DONE: pass=fail=0; key_find and isDark hold. Leaving the stage (any other state) gives IDLE on the next edge.
- Stage exit mid-operation: if state leaves STAGE1/2/3 while in LOAD/SEEK/CONFIRM, go to IDLE on the next edge, clear outputs, and generate no pulse.
- FAIL->STAGE3 retry: passes through IDLE, and re-entry to the stage reloads everything.
- pass and fail are never high in the same cycle and never high outside a stage state.

Decomposition:
- game_pkg contains:
  - state codes
  - obj_kind codes
  - PLAYER_W default
  - object tables (px):
    - STAGE1 keys: (100,40), (200,60), (230,200)
    - STAGE2: light (70,40); keys (120,100), (180,130), (70,190)
    - STAGE3 keys: (90,210), (200,210), (240,40)
    - door, all stages: (250,120)
- Sub-module box_overlap: combinational, parameterised widths, instantiated twice (player/object, player/boss).

Test Plan:
- Reset released, state=STAGE1 -> 2 clk later obj_kind=KEY, obj=(100,40), key_find=0, isDark=0.
- STAGE1, player (95,35), 2 ticks -> key_find=1 on the 2nd tick edge and obj=(200,60). Player moves off after 1 tick -> key_find stays 0.
- STAGE2 entry -> isDark=1, obj_kind=LIGHT (70,40). Hold on light for 2 ticks -> isDark=0, obj=(120,100).
- STAGE1 with 3 keys collected, player (248,118) for 2 ticks -> single-cycle pass=1, obj_kind=NONE. Switch state to SUCCESS1 -> outputs return to reset values.
- STAGE3, boss=(player_x+5, player_y), 1 tick -> fail=1 for one cycle. With the door confirm on the same tick -> fail only, pass=0.
- STAGE3 with key_find=2, then state to FAIL and back to STAGE3 -> key_find=0, obj=(90,210). Assert rst low mid-CONFIRM -> all outputs 0 immediately.
